seven_seg_mux_ctrl: RTL

//  Parametrised N-digit multiplexed seven-segment controller with a built-in refresh prescaler.

---
 rtl/seven_seg_pkg.sv | 26 ++
 rtl/seven_seg_hex_rom.sv | 11 +
 rtl/seven_seg_mux_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display path.
// Segment patterns are active-high, bit order gfedcba (bit 0 = segment a).
package seven_seg_pkg;

  localparam int unsigned MAX_DIGITS = 32;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

  // Callers truncate the result to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [4:0] idx);
    logic [MAX_DIGITS-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/seven_seg_hex_rom.sv
// Combinational hex-nibble to seven-segment decoder (active-high gfedcba).
module seven_seg_hex_rom
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_mux_ctrl.sv
// N-digit multiplexed seven-segment controller: refresh prescaler, double-buffered frame
// writes committed on frame boundaries, registered anode/segment outputs.
// Optional macro SEVEN_SEG_DIM_EN adds a brightness port and PWM anode dimming.
module seven_seg_mux_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_BITS   = 17,
  parameter int ACTIVE_LOW = 1,
  parameter int DIM_BITS   = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [4*NUM_DIGITS-1:0]       wr_data,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
`ifdef SEVEN_SEG_DIM_EN
  input  logic [DIM_BITS-1:0]           brightness,
`endif
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    segs
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]     prescaler_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_d;
  logic [4*NUM_DIGITS-1:0] pending_q;
  logic                    pending_valid_q;
  logic [4*NUM_DIGITS-1:0] display_q;
  logic [NUM_DIGITS-1:0]   anode_d;
  logic [NUM_DIGITS-1:0]   anode_q;
  logic [6:0]              segs_d;
  logic [6:0]              segs_q;
  logic                    tick;
  logic                    frame_end;
  logic                    accept;
  logic                    commit;
  logic                    dim_on;
  logic [3:0]              cur_nibble;
  logic [6:0]              hex_seg;

  assign tick      = &prescaler_q;
  assign frame_end = tick && (idx_q == LAST_IDX);
  assign accept    = wr_valid && !pending_valid_q;
  // A write accepted on the frame_end cycle sees an empty pending slot, so it
  // cannot commit until the following frame boundary.
  assign commit    = frame_end && pending_valid_q;
  assign idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_q <= '0;
      idx_q       <= '0;
    end else begin
      prescaler_q <= prescaler_q + 1'b1;
      if (tick) begin
        idx_q <= idx_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      display_q       <= '0;
    end else begin
      if (accept) begin
        pending_q       <= wr_data;
        pending_valid_q <= 1'b1;
      end else if (commit) begin
        display_q       <= pending_q;
        pending_valid_q <= 1'b0;
      end
    end
  end

  assign cur_nibble = display_q[{idx_q, 2'b00} +: 4];

  seven_seg_hex_rom u_hex_rom (
    .nibble_i (cur_nibble),
    .seg_o    (hex_seg)
  );

`ifdef SEVEN_SEG_DIM_EN
  // Top prescaler bits act as the PWM phase within the digit slot.
  assign dim_on = (prescaler_q[DIV_BITS-1 -: DIM_BITS] <= brightness);
`else
  assign dim_on = 1'b1;
`endif

  always_comb begin
    anode_d = '0;
    segs_d  = SEG_OFF;
    if (!blank_mask[idx_q]) begin
      segs_d = hex_seg;
      if (dim_on) begin
        anode_d = NUM_DIGITS'(onehot(5'(idx_q)));
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anode_q <= '0;
      segs_q  <= SEG_OFF;
    end else begin
      anode_q <= anode_d;
      segs_q  <= segs_d;
    end
  end

  assign wr_ready  = !pending_valid_q;
  assign digit_idx = idx_q;
  assign anode     = (ACTIVE_LOW != 0) ? ~anode_q : anode_q;
  assign segs      = (ACTIVE_LOW != 0) ? ~segs_q  : segs_q;

endmodule
